// File: rtl/sobel_stream_pkg.sv
// Shared definitions for the Sobel streaming edge detector.
//   - default parameter values (pixel width, maximum line width, counter width)
//   - minimum usable line width (a 3x3 window needs at least 3 columns)
//   - FSM state encoding used by sobel_stream
//   - helper to size row-buffer address pointers
package sobel_stream_pkg;

    localparam int unsigned DEF_PIX_W      = 8;
    localparam int unsigned DEF_MAX_WIDTH  = 1024;
    localparam int unsigned DEF_XW         = 11;
    localparam int unsigned MIN_LINE_WIDTH = 3;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    function automatic int unsigned addr_bits(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// Circular row buffer: delays a pixel stream by exactly `width` enabled cycles.
// Ports:
//   clk      in   clock, rising edge
//   reset_n  in   synchronous active-low reset (pointer only; RAM is not reset)
//   en       in   advance: write din, step the pointer
//   restart  in   qualified by en: this pixel is written at address 0
//   width    in   current line length W (3..MAX_WIDTH)
//   din      in   pixel written this cycle
//   dout     out  pixel written W enabled cycles ago (combinational read)
module sobel_line_buffer
    import sobel_stream_pkg::*;
#(
    parameter int unsigned PIX_W     = DEF_PIX_W,
    parameter int unsigned MAX_WIDTH = DEF_MAX_WIDTH,
    parameter int unsigned XW        = DEF_XW
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             restart,
    input  logic [XW-1:0]    width,
    input  logic [PIX_W-1:0] din,
    output logic [PIX_W-1:0] dout
);

    localparam int unsigned AW = addr_bits(MAX_WIDTH);

    logic [PIX_W-1:0] mem [MAX_WIDTH];
    logic [AW-1:0]    ptr;
    logic [AW-1:0]    ptr_cur;
    logic             at_last;

    // Read-before-write at the same address gives a delay of exactly W.
    always_comb begin
        ptr_cur = restart ? '0 : ptr;
        at_last = (XW'(ptr_cur) == (width - XW'(1)));
    end

    assign dout = mem[ptr_cur];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ptr <= '0;
        end else if (en) begin
            ptr <= at_last ? '0 : ptr_cur + AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            mem[ptr_cur] <= din;
        end
    end

endmodule

// File: rtl/sobel_stream.sv
// Streaming 3x3 Sobel edge detector. Two cascaded row buffers feed a 3x3
// window; each completed interior window emits |dx|+|dy| one cycle after the
// pixel that completed it was accepted. Border pixels produce no output.
// Optional build macro: SOBEL_THRESHOLD_EN adds the thresh port and turns the
// output into a binary map (mag > thresh -> all ones, else zero).
// Ports:
//   clk         in   clock, rising edge
//   reset_n     in   synchronous active-low reset
//   line_width  in   active line width, latched on an accepted in_sof pixel
//   in_valid    in   in_data valid this cycle (no backpressure)
//   in_sof      in   with in_valid: pixel (0,0) of a new frame
//   in_data     in   intensity pixel
//   thresh      in   binarisation threshold (SOBEL_THRESHOLD_EN only)
//   out_valid   out  out_data valid
//   out_sof     out  first interior pixel of the frame
//   out_data    out  saturated magnitude or binary value; holds when idle
module sobel_stream
    import sobel_stream_pkg::*;
#(
    parameter int unsigned PIX_W     = DEF_PIX_W,
    parameter int unsigned MAX_WIDTH = DEF_MAX_WIDTH,
    parameter int unsigned XW        = DEF_XW
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [XW-1:0]    line_width,
    input  logic             in_valid,
    input  logic             in_sof,
    input  logic [PIX_W-1:0] in_data,
`ifdef SOBEL_THRESHOLD_EN
    input  logic [PIX_W-1:0] thresh,
`endif
    output logic             out_valid,
    output logic             out_sof,
    output logic [PIX_W-1:0] out_data
);

    localparam int unsigned SW = PIX_W + 3;
    localparam int unsigned MW = PIX_W + 4;

    localparam logic [PIX_W-1:0] MAX_PIX = '1;
    localparam logic [XW-1:0]    W_MIN   = XW'(MIN_LINE_WIDTH);
    localparam logic [XW-1:0]    W_MAX   = XW'(MAX_WIDTH);
    localparam logic [XW-1:0]    Y_MAX   = '1;

    // ---------------------------------------------------------------- FSM
    state_t state, state_nxt;
    logic   accept;
    logic   restart;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (in_valid && in_sof) state_nxt = RUN;
            RUN:  state_nxt = RUN;
        endcase
    end

    always_comb begin
        accept = 1'b0;
        case (state)
            IDLE: accept = in_valid && in_sof;
            RUN:  accept = in_valid;
        endcase
        restart = accept && in_sof;
    end

    // ------------------------------------------------------- position track
    // On a restart the current pixel is (0,0) and uses the freshly clamped
    // width, so the *_cur values are what this pixel actually sees.
    logic [XW-1:0] w_reg, w_clamped, w_cur;
    logic [XW-1:0] x, y, x_cur, y_cur;
    logic          last_col;

    always_comb begin
        if (line_width < W_MIN) begin
            w_clamped = W_MIN;
        end else if (line_width > W_MAX) begin
            w_clamped = W_MAX;
        end else begin
            w_clamped = line_width;
        end
        w_cur    = restart ? w_clamped : w_reg;
        x_cur    = restart ? '0 : x;
        y_cur    = restart ? '0 : y;
        last_col = (x_cur == (w_cur - XW'(1)));
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            x     <= '0;
            y     <= '0;
            w_reg <= W_MIN;
        end else if (accept) begin
            w_reg <= w_cur;
            if (last_col) begin
                x <= '0;
                y <= (y_cur == Y_MAX) ? y_cur : y_cur + XW'(1);
            end else begin
                x <= x_cur + XW'(1);
                y <= y_cur;
            end
        end
    end

    // --------------------------------------------------------- row buffers
    logic [PIX_W-1:0] rb0, rb1;

    sobel_line_buffer #(
        .PIX_W    (PIX_W),
        .MAX_WIDTH(MAX_WIDTH),
        .XW       (XW)
    ) u_row0 (
        .clk    (clk),
        .reset_n(reset_n),
        .en     (accept),
        .restart(restart),
        .width  (w_cur),
        .din    (in_data),
        .dout   (rb0)
    );

    sobel_line_buffer #(
        .PIX_W    (PIX_W),
        .MAX_WIDTH(MAX_WIDTH),
        .XW       (XW)
    ) u_row1 (
        .clk    (clk),
        .reset_n(reset_n),
        .en     (accept),
        .restart(restart),
        .width  (w_cur),
        .din    (rb0),
        .dout   (rb1)
    );

    // -------------------------------------------------------------- window
    // p1 p2 p3  <- row y-2 (rb1)
    // p4 p5 p6  <- row y-1 (rb0)
    // p7 p8 p9  <- row y   (in_data)
    logic [PIX_W-1:0] p1, p2, p3, p4, p5, p6, p7, p8, p9;
    logic [PIX_W-1:0] n1, n2, n3, n4, n5, n6, n7, n8, n9;

    always_comb begin
        n1 = p2;  n2 = p3;  n3 = rb1;
        n4 = p5;  n5 = p6;  n6 = rb0;
        n7 = p8;  n8 = p9;  n9 = in_data;
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            p1 <= n1;  p2 <= n2;  p3 <= n3;
            p4 <= n4;  p5 <= n5;  p6 <= n6;
            p7 <= n7;  p8 <= n8;  p9 <= n9;
        end
    end

    // ---------------------------------------------------------- arithmetic
    // Kernel is evaluated on the post-shift window so the result can be
    // registered on the same edge that accepts the completing pixel.
    logic [SW-1:0]    sum_l, sum_r, sum_t, sum_b, dx, dy, adx, ady;
    logic [MW-1:0]    mag;
    logic [PIX_W-1:0] result;

    always_comb begin
        sum_l = SW'(n1) + (SW'(n4) << 1) + SW'(n7);
        sum_r = SW'(n3) + (SW'(n6) << 1) + SW'(n9);
        sum_t = SW'(n1) + (SW'(n2) << 1) + SW'(n3);
        sum_b = SW'(n7) + (SW'(n8) << 1) + SW'(n9);
        dx    = sum_l - sum_r;
        dy    = sum_t - sum_b;
        adx   = dx[SW-1] ? (SW'(0) - dx) : dx;
        ady   = dy[SW-1] ? (SW'(0) - dy) : dy;
        mag   = MW'(adx) + MW'(ady);
`ifdef SOBEL_THRESHOLD_EN
        result = (mag > MW'(thresh)) ? MAX_PIX : '0;
`else
        result = (mag > MW'(MAX_PIX)) ? MAX_PIX : mag[PIX_W-1:0];
`endif
    end

    // -------------------------------------------------------------- output
    logic emit, first;

    always_comb begin
        emit  = accept && (x_cur >= XW'(2)) && (y_cur >= XW'(2));
        first = (x_cur == XW'(2)) && (y_cur == XW'(2));
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            out_data  <= '0;
        end else begin
            out_valid <= emit;
            out_sof   <= emit && first;
            if (emit) begin
                out_data <= result;
            end
        end
    end

endmodule

// File: tb/tb_sobel_stream.sv
module tb_sobel_stream;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] line_width;
    logic       in_valid;
    logic       in_sof;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_sof;
    logic [7:0] out_data;
`ifdef SOBEL_THRESHOLD_EN
    logic [7:0] thresh;
`endif

    always #5 clk = ~clk;

    sobel_stream #(
        .PIX_W    (8),
        .MAX_WIDTH(8),
        .XW       (4)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .line_width(line_width),
        .in_valid  (in_valid),
        .in_sof    (in_sof),
        .in_data   (in_data),
`ifdef SOBEL_THRESHOLD_EN
        .thresh    (thresh),
`endif
        .out_valid (out_valid),
        .out_sof   (out_sof),
        .out_data  (out_data)
    );

    int passed = 0;
    int total  = 0;
    int cyc    = 0;

    int         exp_cyc [$];
    logic [7:0] got_d   [$];
    logic       got_s   [$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, want %0d", name, act, exp);
    endtask

    // Every output must land exactly one cycle after a qualifying pixel.
    always @(negedge clk) begin
        if (out_valid) begin
            got_d.push_back(out_data);
            got_s.push_back(out_sof);
            if (exp_cyc.size() == 0) check("unexpected_out", cyc, -1);
            else check("latency", cyc, exp_cyc.pop_front());
        end
    end

    function automatic logic [7:0] pix(input int pat, input int x, input int y);
        case (pat)
            0:       return 8'd100;
            1:       return (x < 2) ? 8'd0 : 8'd255;
            2:       return 8'(10 * x);
            default: return 8'(20 * y);
        endcase
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input bit sof, input logic [7:0] d, input bit qual);
        in_valid = 1'b1;
        in_sof   = sof;
        in_data  = d;
        if (qual) exp_cyc.push_back(cyc + 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic run_frame(input int pat, input logic [3:0] lw, input int weff,
                             input int h, input bit gaps);
        got_d.delete();
        got_s.delete();
        line_width = lw;
        for (int y = 0; y < h; y++) begin
            for (int x = 0; x < weff; x++) begin
                if (gaps && ($urandom_range(0, 2) == 0)) idle(1 + $urandom_range(0, 1));
                send((x == 0) && (y == 0), pix(pat, x, y), (x >= 2) && (y >= 2));
            end
        end
        idle(3);
        check("pending_outputs", exp_cyc.size(), 0);
    endtask

    task automatic cmp_frame(input string tag, input logic [47:0] ev, input int n);
        check({tag, "_count"}, got_d.size(), n);
        for (int k = 0; k < n && k < got_d.size(); k++) begin
            check({tag, "_data"}, got_d[k], ev[8*(5-k) +: 8]);
            check({tag, "_sof"}, got_s[k], (k == 0) ? 1 : 0);
        end
        if (n > 0) check({tag, "_hold"}, out_data, ev[8*(5-(n-1)) +: 8]);
    endtask

    typedef struct packed {
        logic [1:0]  pat;
        logic        gaps;
        logic [7:0]  thr;
        logic [47:0] exp_mag;
        logic [47:0] exp_thr;
    } vec_t;

    vec_t        v [4];
    logic [47:0] ev;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1);
    end

    initial begin
        // 5-wide, 4-row frames: interior outputs in order (1,1)(2,1)(3,1)(1,2)(2,2)(3,2)
        v[0] = '{2'd0, 1'b0, 8'd50, {6{8'd0}},                                {6{8'd0}}};
        v[1] = '{2'd1, 1'b0, 8'd50, {8'd255, 8'd255, 8'd0, 8'd255, 8'd255, 8'd0},
                                    {8'd255, 8'd255, 8'd0, 8'd255, 8'd255, 8'd0}};
        v[2] = '{2'd2, 1'b0, 8'd50, {6{8'd80}},                               {6{8'd255}}};
        v[3] = '{2'd2, 1'b1, 8'd80, {6{8'd80}},                               {6{8'd0}}};

        reset_n    = 1'b0;
        line_width = 4'd5;
        in_valid   = 1'b0;
        in_sof     = 1'b0;
        in_data    = '0;
`ifdef SOBEL_THRESHOLD_EN
        thresh     = 8'd50;
`endif
        idle(3);
        check("reset_out_valid", out_valid, 0);
        check("reset_out_sof", out_sof, 0);
        check("reset_out_data", out_data, 0);
        reset_n = 1'b1;
        idle(2);

        // Pixels without in_sof are ignored while idle.
        got_d.delete();
        for (int k = 0; k < 15; k++) send(1'b0, 8'(k * 17), 1'b0);
        idle(3);
        check("idle_ignored", got_d.size(), 0);

        for (int i = 0; i < 4; i++) begin
`ifdef SOBEL_THRESHOLD_EN
            thresh = v[i].thr;
            ev = v[i].exp_thr;
`else
            ev = v[i].exp_mag;
`endif
            run_frame(int'(v[i].pat), 4'd5, 5, 4, v[i].gaps);
            cmp_frame($sformatf("vec%0d", i), ev, 6);
        end

        // Mid-frame restart with a too-narrow width: W clamps to 3.
`ifdef SOBEL_THRESHOLD_EN
        thresh = 8'd50;
        ev = {8'd255, 8'd255, 32'd0};
`else
        ev = {8'd160, 8'd160, 32'd0};
`endif
        line_width = 4'd5;
        got_d.delete();
        for (int k = 0; k < 7; k++) send(k == 0, 8'(30 + 9 * k), 1'b0);
        run_frame(3, 4'd2, 3, 4, 1'b0);
        cmp_frame("restart_w3", ev, 2);

        // Reset in the middle of a frame.
        line_width = 4'd5;
        got_d.delete();
        for (int k = 0; k < 12; k++) send(k == 0, pix(2, k % 5, k / 5), 1'b0);
        check("pre_reset_hold", out_data, ev[47:40]);
        reset_n  = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'd200;
        @(posedge clk);
        #1;
        reset_n  = 1'b1;
        in_valid = 1'b0;
        check("midreset_out_valid", out_valid, 0);
        check("midreset_out_data", out_data, 0);
        check("midreset_out_sof", out_sof, 0);
        for (int k = 0; k < 10; k++) send(1'b0, pix(2, k % 5, 3), 1'b0);
        idle(3);
        check("post_reset_ignored", got_d.size(), 0);

`ifdef SOBEL_THRESHOLD_EN
        thresh = v[2].thr;
        ev = v[2].exp_thr;
`else
        ev = v[2].exp_mag;
`endif
        run_frame(2, 4'd5, 5, 4, 1'b0);
        cmp_frame("post_reset_frame", ev, 6);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
